regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port general-purpose register file with write-back bypass and a per-register pending-write scoreboard. It replaces the fixed 32×32, two-read/one-write register file between decode and write-back. Decode reads operands and uses the busy flags to stall. Write-back retires up to two results per cycle.

## Interface
- DW, 32, register data width in bits
- AW, 5, register address width; depth = 2^AW
- NR, 2, number of read ports (1..4); per-port fields are packed, port k occupies slice [k*W +: W]

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset; all registers and scoreboard bits clear while low
- we  in  2  write enable, bit j = write port j (port 1 is the younger retirement)
- waddr  in  2*AW  write addresses
- wdata  in  2*DW  write data
- re  in  NR  read enable per port
- raddr  in  NR*AW  read addresses
- rdata  out  NR*DW  read data, combinational
- rbusy  out  NR  target register has a pending write, combinational
- sb_set  in  1  mark sb_addr pending (decode issued an instruction writing it)
- sb_addr  in  AW  register to mark
- sb_busy_any  out  1  OR of all scoreboard bits, registered

## Operation
- Storage: 2^AW entries × DW bits. Entry 0 is hardwired to zero. Writes to address 0 are dropped. Entry 0 is never marked busy.
- Write: on posedge clk, if we[j] is set and waddr[j] != 0, the entry takes wdata[j]. If both ports write the same address, port 1 wins.
- Read port k, evaluated in priority order:
  - reset asserted: output 0
  - raddr[k] == 0: output 0
  - re[k] == 0: output 0
  - we[1] and waddr[1] == raddr[k]: output wdata[1]
  - we[0] and waddr[0] == raddr[k]: output wdata[0]
  - otherwise: stored entry
- rbusy[k]:
  - Equals the scoreboard bit for raddr[k], masked to 0 when re[k]=0 or raddr[k]=0.
  - Also forced to 0 when a same-cycle write-back to that address is clearing the bit, because the bypass already supplies the data.
- Scoreboard update per clock, per address a:
  - set condition: sb_set and sb_addr == a and a != 0
  - clear condition: (we[0] and waddr[0]==a) or (we[1] and waddr[1]==a)
  - If set and clear hit the same address together, set wins: the new producer is still outstanding.
- sb_busy_any is registered. It reflects the scoreboard state after the current edge's update, so it is valid one cycle after the update.
- Bypass and rbusy ignore sb_set in the same cycle. A read in the cycle of its producer's issue sees busy only from the next cycle.

## Timing
- Write latency: 1 cycle to storage. Read-after-write in the same cycle is 0 latency via bypass.
- Scoreboard: set/clear take effect at the next rising edge. rbusy reflects them from that edge onward.
- Reset values:
  - all entries = 0, all scoreboard bits = 0, sb_busy_any = 0
  - while rst=0: rdata = 0, rbusy = 0
- Reset mid-operation: clears immediately and asynchronously. Any write at the same edge is lost.
- After rst deasserts, the first write is accepted at the first rising edge with rst high.
- All outputs except sb_busy_any are combinational from inputs and state. No read-port stall or handshake exists; the consumer stalls on rbusy.

## Test plan
- Reset: load r5=0xDEADBEEF, pull rst low mid-cycle -> rdata for r5 = 0 and rbusy = 0 immediately; after release r5 still reads 0.
- Zero register: we[0]=1, waddr=0, wdata=0xFFFFFFFF; sb_set on r0 -> r0 reads 0, rbusy=0, sb_busy_any stays 0.
- Dual write conflict: both ports write r7, port0=0x11, port1=0x22 -> same-cycle read of r7 = 0x22; after the edge stored r7 = 0x22.
- Bypass: r3=0x10 stored, then we[0]=1 to r3 with 0x99 while reading r3 on all NR ports -> every port reads 0x99 that cycle.
- Scoreboard lifecycle: sb_set r9 -> next cycle rbusy=1 and sb_busy_any=1; write-back to r9 with 0x5A -> rbusy=0 that cycle, rdata=0x5A; next cycle sb_busy_any=0.
- Set/clear collision: r4 busy; in one cycle write-back r4 and sb_set r4 -> r4 remains busy next cycle, with stored value updated.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bus between decode/write-back (master) and the register file (slave).
// Per-port fields are packed; port k occupies slice [k*W +: W].
interface regfile_sb_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
);
    logic [1:0]       we;
    logic [2*AW-1:0]  waddr;
    logic [2*DW-1:0]  wdata;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic             sb_busy_any;

    modport master (
        output we, waddr, wdata, re, raddr, sb_set, sb_addr,
        input  rdata, rbusy, sb_busy_any
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, sb_set, sb_addr,
        output rdata, rbusy, sb_busy_any
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with two write-back ports, same-cycle bypass
// and a per-register pending-write scoreboard used by decode to stall.
module regfile_sb #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] sb;
    logic [DEPTH-1:0] sb_clr;
    logic [DEPTH-1:0] sb_nxt;
    logic             busy_any_q;
    logic [AW-1:0]    wa0, wa1;
    logic [DW-1:0]    wd0, wd1;
    logic [NR*DW-1:0] rdata_c;
    logic [NR-1:0]    rbusy_c;

    assign wa0 = bus.waddr[0  +: AW];
    assign wa1 = bus.waddr[AW +: AW];
    assign wd0 = bus.wdata[0  +: DW];
    assign wd1 = bus.wdata[DW +: DW];

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sb_clr = '0;
        if (bus.we[0]) sb_clr[wa0] = 1'b1;
        if (bus.we[1]) sb_clr[wa1] = 1'b1;
        sb_nxt = sb & ~sb_clr;
        // A new issue outranks a retiring write: the new producer is still outstanding.
        if (bus.sb_set && bus.sb_addr != '0) sb_nxt[bus.sb_addr] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    // NOTE: the storage array is reset explicitly because all entries must read zero after reset.
    // NOTE: sequential state uses non-blocking assignments; the later port-1 write therefore wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            sb         <= '0;
            busy_any_q <= 1'b0;
        end else begin
            if (bus.we[0] && wa0 != '0) mem[wa0] <= wd0;
            if (bus.we[1] && wa1 != '0) mem[wa1] <= wd1;
            sb         <= sb_nxt;
            busy_any_q <= |sb_nxt;
        end
    end

    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] ra;
            ra = bus.raddr[k*AW +: AW];
            if (rst && bus.re[k] && ra != '0) begin
                if (bus.we[1] && wa1 == ra)
                    rdata_c[k*DW +: DW] = wd1;
                else if (bus.we[0] && wa0 == ra)
                    rdata_c[k*DW +: DW] = wd0;
                else
                    rdata_c[k*DW +: DW] = mem[ra];
                // A retiring write is already bypassed, so it must not stall the reader.
                rbusy_c[k] = sb[ra] & ~sb_clr[ra];
            end
        end
    end

    assign bus.rdata       = rdata_c;
    assign bus.rbusy       = rbusy_c;
    assign bus.sb_busy_any = busy_any_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array-based
// reference model of the register file and scoreboard.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.DW(DW), .AW(AW), .NR(NR)) bus ();

    regfile_sb #(.DW(DW), .AW(AW), .NR(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_sb  [DEPTH];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rd_addr(int k);
        return bus.raddr[k*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] wr_addr(int j);
        return bus.waddr[j*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wr_data(int j);
        return bus.wdata[j*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] exp_rdata(int k);
        logic [AW-1:0] a;
        a = rd_addr(k);
        if (!rst || a == 0 || !bus.re[k]) return '0;
        if (bus.we[1] && wr_addr(1) == a) return wr_data(1);
        if (bus.we[0] && wr_addr(0) == a) return wr_data(0);
        return m_mem[a];
    endfunction

    function automatic logic exp_rbusy(int k);
        logic [AW-1:0] a;
        a = rd_addr(k);
        if (!rst || a == 0 || !bus.re[k]) return 1'b0;
        for (int j = 0; j < 2; j++)
            if (bus.we[j] && wr_addr(j) == a) return 1'b0;
        return m_sb[a];
    endfunction

    function automatic logic model_any();
        for (int i = 0; i < DEPTH; i++)
            if (m_sb[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_sb[i]  = 1'b0;
        end
    endtask

    task automatic model_clock();
        for (int j = 0; j < 2; j++)
            if (bus.we[j]) begin
                if (wr_addr(j) != 0) m_mem[wr_addr(j)] = wr_data(j);
                m_sb[wr_addr(j)] = 1'b0;
            end
        if (bus.sb_set && bus.sb_addr != 0) m_sb[bus.sb_addr] = 1'b1;
    endtask

    task automatic check_ports(input string tag);
        for (int k = 0; k < NR; k++) begin
            check($sformatf("%s_rdata%0d", tag, k), bus.rdata[k*DW +: DW], exp_rdata(k));
            check($sformatf("%s_rbusy%0d", tag, k), bus.rbusy[k], exp_rbusy(k));
        end
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic tick(input string tag);
        #1;
        check_ports(tag);
        @(posedge clk);
        if (rst) model_clock();
        else     model_reset();
        #1;
        check({tag, "_any"}, bus.sb_busy_any, model_any());
        @(negedge clk);
    endtask

    task automatic idle();
        bus.we      = '0;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.re      = '0;
        bus.raddr   = '0;
        bus.sb_set  = 1'b0;
        bus.sb_addr = '0;
    endtask

    task automatic set_read(input int k, input logic [AW-1:0] a);
        bus.re[k] = 1'b1;
        bus.raddr[k*AW +: AW] = a;
    endtask

    task automatic set_write(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we[j] = 1'b1;
        bus.waddr[j*AW +: AW] = a;
        bus.wdata[j*DW +: DW] = d;
    endtask

    task automatic set_issue(input logic [AW-1:0] a);
        bus.sb_set  = 1'b1;
        bus.sb_addr = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle();
        rst = 1'b0;
        set_read(0, 5);
        set_read(1, 9);
        #2;
        check_ports("rst");
        check("rst_any", bus.sb_busy_any, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Register 0 ignores writes and issues.
        idle(); set_write(0, 0, 32'hFFFF_FFFF); set_issue(0); set_read(0, 0); set_read(1, 0);
        tick("zero");
        idle(); set_read(0, 0);
        #1;
        check("zero_any", bus.sb_busy_any, 1'b0);
        tick("zero2");

        // Both write ports hit r7; port 1 must win.
        idle(); set_write(0, 7, 32'h11); set_write(1, 7, 32'h22); set_read(0, 7); set_read(1, 7);
        #1;
        check("dual_bypass", bus.rdata[0 +: DW], 32'h22);
        tick("dual");
        idle(); set_read(0, 7);
        #1;
        check("dual_store", bus.rdata[0 +: DW], 32'h22);
        tick("dual2");

        // Bypass on every read port.
        idle(); set_write(0, 3, 32'h10);
        tick("byp_ld");
        idle(); set_write(0, 3, 32'h99);
        for (int k = 0; k < NR; k++) set_read(k, 3);
        #1;
        for (int k = 0; k < NR; k++)
            check($sformatf("byp_port%0d", k), bus.rdata[k*DW +: DW], 32'h99);
        tick("byp");

        // Scoreboard lifecycle on r9.
        idle(); set_issue(9); set_read(0, 9);
        #1;
        check("sb_issue_nobusy", bus.rbusy[0], 1'b0);
        tick("sb_set");
        idle(); set_read(0, 9);
        #1;
        check("sb_busy", bus.rbusy[0], 1'b1);
        check("sb_any1", bus.sb_busy_any, 1'b1);
        tick("sb_wait");
        idle(); set_write(1, 9, 32'h5A); set_read(0, 9);
        #1;
        check("sb_wb_busy", bus.rbusy[0], 1'b0);
        check("sb_wb_data", bus.rdata[0 +: DW], 32'h5A);
        tick("sb_wb");
        idle();
        #1;
        check("sb_any0", bus.sb_busy_any, 1'b0);
        tick("sb_idle");

        // Issue and retire to r4 in the same cycle: stays busy, value updates.
        idle(); set_issue(4);
        tick("col_set");
        idle(); set_write(0, 4, 32'h44); set_issue(4);
        tick("col");
        idle(); set_read(1, 4);
        #1;
        check("col_busy", bus.rbusy[1], 1'b1);
        check("col_data", bus.rdata[DW +: DW], 32'h44);
        tick("col2");

        // Random traffic, biased to a few low registers so collisions are frequent.
        for (int n = 0; n < 500; n++) begin
            idle();
            for (int j = 0; j < 2; j++)
                if ($urandom_range(0, 2) == 0)
                    set_write(j, AW'($urandom_range(0, 7)), $urandom);
            for (int k = 0; k < NR; k++)
                if ($urandom_range(0, 3) != 0)
                    set_read(k, ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)));
            if ($urandom_range(0, 2) == 0) set_issue(AW'($urandom_range(0, 7)));
            tick("rnd");
        end

        // Asynchronous reset in the middle of a cycle.
        idle(); set_write(0, 5, 32'hDEAD_BEEF); set_issue(5);
        tick("mr_ld");
        idle(); set_read(0, 5); set_read(1, 5);
        #1;
        check("mr_pre_data", bus.rdata[0 +: DW], 32'hDEAD_BEEF);
        check("mr_pre_busy", bus.rbusy[0], 1'b1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("mr_data", bus.rdata[0 +: DW], '0);
        check("mr_busy", bus.rbusy, '0);
        check("mr_any", bus.sb_busy_any, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(); set_read(0, 5);
        #1;
        check("mr_after", bus.rdata[0 +: DW], '0);
        tick("mr_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
